// File: rtl/comparator_pipe.sv
// Two-stage valid/ready magnitude comparator with per-pair signed/unsigned mode.
// Optional result statistics counters are built when CMP_STATS_EN is defined.
module comparator_pipe #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             signed_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             a_gt_b,
    output logic             a_eq_b,
    output logic             a_lt_b
`ifdef CMP_STATS_EN
    ,
    input  logic             stats_clr,
    output logic [CNT_W-1:0] gt_cnt,
    output logic [CNT_W-1:0] eq_cnt,
    output logic [CNT_W-1:0] lt_cnt
`endif
);

    logic             s1_valid_q;
    logic [WIDTH-1:0] s1_a_q;
    logic [WIDTH-1:0] s1_b_q;
    logic             s1_signed_q;

    logic             s2_valid_q;
    logic             gt_q;
    logic             eq_q;
    logic             lt_q;

    logic             s2_adv;
    logic             s1_adv;
    logic [WIDTH-1:0] a_key;
    logic [WIDTH-1:0] b_key;
    logic             cmp_gt;
    logic             cmp_eq;
    logic             cmp_lt;

    assign s2_adv   = !s2_valid_q || out_ready;
    assign s1_adv   = !s1_valid_q || s2_adv;
    assign in_ready = !rst && s1_adv;

    // Flipping the sign bit maps two's-complement order onto unsigned order.
    always_comb begin
        a_key            = s1_a_q;
        b_key            = s1_b_q;
        a_key[WIDTH-1]   = s1_a_q[WIDTH-1] ^ s1_signed_q;
        b_key[WIDTH-1]   = s1_b_q[WIDTH-1] ^ s1_signed_q;
        cmp_gt           = a_key > b_key;
        cmp_eq           = a_key == b_key;
        cmp_lt           = a_key < b_key;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s1_signed_q <= 1'b0;
            s2_valid_q  <= 1'b0;
            gt_q        <= 1'b0;
            eq_q        <= 1'b0;
            lt_q        <= 1'b0;
        end else begin
            if (s1_adv) begin
                s1_valid_q <= in_valid;
                if (in_valid) begin
                    s1_a_q      <= a;
                    s1_b_q      <= b;
                    s1_signed_q <= signed_mode;
                end
            end
            if (s2_adv) begin
                s2_valid_q <= s1_valid_q;
                gt_q       <= s1_valid_q && cmp_gt;
                eq_q       <= s1_valid_q && cmp_eq;
                lt_q       <= s1_valid_q && cmp_lt;
            end
        end
    end

    assign out_valid = s2_valid_q;
    assign a_gt_b    = gt_q;
    assign a_eq_b    = eq_q;
    assign a_lt_b    = lt_q;

`ifdef CMP_STATS_EN
    localparam logic [CNT_W-1:0] CntMax = '1;
    localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

    logic out_hs;
    assign out_hs = s2_valid_q && out_ready;

    // Clear wins over a same-cycle increment; counters stick at all-ones.
    always_ff @(posedge clk) begin
        if (rst || stats_clr) begin
            gt_cnt <= '0;
            eq_cnt <= '0;
            lt_cnt <= '0;
        end else if (out_hs) begin
            if (gt_q && gt_cnt != CntMax) gt_cnt <= gt_cnt + CntOne;
            if (eq_q && eq_cnt != CntMax) eq_cnt <= eq_cnt + CntOne;
            if (lt_q && lt_cnt != CntMax) lt_cnt <= lt_cnt + CntOne;
        end
    end
`endif

endmodule
